// File: rtl/div_ratio_monitor_pkg.sv
// Shared clock-generation definitions: monitor state encoding and the
// default divide ratio / duty used by the divider and its monitor.
package div_ratio_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam int DEF_EXP_PERIOD = 3;
   localparam int DEF_EXP_HIGH   = 1;

endpackage

// File: rtl/div_ratio_monitor_edge_period_counter.sv
// Rising-edge detector plus period / high-time counters for a clk-synchronous
// divided signal; flags a timeout when the period counter reaches its maximum.
module edge_period_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             arm,
   input  logic             meas,
   input  logic             sig_in,
   output logic             rise,
   output logic             timeout,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] hcnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic sig_q;

   assign rise    = sig_in & ~sig_q;
   assign timeout = meas & ~rise & (cnt == CNT_MAX);

   // sig_q tracks sig_in even while idle so an already-high input is not a rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
         cnt   <= '0;
         hcnt  <= '0;
      end else begin
         sig_q <= sig_in;
         if (clear) begin
            cnt  <= '0;
            hcnt <= '0;
         end else if (arm && rise) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
         end else if (meas && !timeout) begin
            cnt  <= cnt + 1'b1;
            hcnt <= hcnt + {{(CNT_W-1){1'b0}}, sig_in};
         end else begin
            cnt  <= '0;
            hcnt <= '0;
         end
      end
   end

endmodule

// File: rtl/div_ratio_monitor.sv
// Divided-clock ratio monitor: measures period and high time between rising
// edges, compares with the expected ratio, and tracks lock / timeout status.
module div_ratio_monitor
   import div_ratio_monitor_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int EXP_PERIOD = DEF_EXP_PERIOD,
   parameter int EXP_HIGH   = DEF_EXP_HIGH,
   parameter int LOCK_CNT   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             meas_valid,
   output logic             match,
   output logic             locked,
   output logic             err
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_CNT);
   localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] EXP_H  = CNT_W'(EXP_HIGH);

   state_t           state;
   logic [MW-1:0]    mcnt;
   logic [MW-1:0]    mcnt_nxt;
   logic             is_match;
   logic             rise;
   logic             timeout;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;

   edge_period_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (~start),
      .arm     (state != IDLE),
      .meas    (state == MEAS),
      .sig_in  (sig_in),
      .rise    (rise),
      .timeout (timeout),
      .cnt     (cnt),
      .hcnt    (hcnt)
   );

   always_comb begin
      is_match = (cnt == EXP_P) && (hcnt == EXP_H);
      mcnt_nxt = '0;
      if (is_match) begin
         mcnt_nxt = (mcnt == LOCK_M) ? mcnt : mcnt + 1'b1;
      end
   end

   // start=0 dominates any simultaneous rise or timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mcnt       <= '0;
         period_o   <= '0;
         high_o     <= '0;
         meas_valid <= 1'b0;
         match      <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
      end else if (!start) begin
         state      <= IDLE;
         mcnt       <= '0;
         period_o   <= '0;
         high_o     <= '0;
         meas_valid <= 1'b0;
         match      <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state)
            IDLE: state <= SEEK;
            SEEK: if (rise) state <= MEAS;
            MEAS: begin
               if (rise) begin
                  period_o   <= cnt;
                  high_o     <= hcnt;
                  meas_valid <= 1'b1;
                  match      <= is_match;
                  mcnt       <= mcnt_nxt;
                  locked     <= (mcnt_nxt == LOCK_M);
               end else if (timeout) begin
                  err    <= 1'b1;
                  mcnt   <= '0;
                  locked <= 1'b0;
                  match  <= 1'b0;
                  state  <= SEEK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Scoreboard bench for div_ratio_monitor: directed periods push expected
// measurements; a monitor pops and compares on every meas_valid.
module tb_div_ratio_monitor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       sig_in;
   logic [7:0] period_o;
   logic [7:0] high_o;
   logic       meas_valid;
   logic       match;
   logic       locked;
   logic       err;

   typedef struct {
      int p;
      int h;
      bit m;
      bit l;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   passes = 0;

   div_ratio_monitor #(
      .CNT_W(8), .EXP_PERIOD(3), .EXP_HIGH(1), .LOCK_CNT(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .sig_in     (sig_in),
      .period_o   (period_o),
      .high_o     (high_o),
      .meas_valid (meas_valid),
      .match      (match),
      .locked     (locked),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic drive(input logic v);
      sig_in = v;
      @(negedge clk);
   endtask

   task automatic period(input int p, input int h, input bit close, input bit m, input bit l);
      exp_t x;
      if (close) begin
         x.p = p; x.h = h; x.m = m; x.l = l;
         q.push_back(x);
      end
      for (int i = 0; i < p; i++) drive(i < h);
   endtask

   task automatic zeros(input string tag);
      chk({tag, "_outputs_zero"},
          int'({period_o, high_o, meas_valid, match, locked, err}), 0);
   endtask

   // Monitor: every meas_valid must consume exactly one expectation
   always @(negedge clk) begin
      if (rst_n && meas_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_meas_valid", 1, 0);
         end else begin
            e = q.pop_front();
            chk("period_o", int'(period_o), e.p);
            chk("high_o",   int'(high_o),   e.h);
            chk("match",    int'(match),    int'(e.m));
            chk("locked",   int'(locked),   int'(e.l));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; sig_in = 1'b0;
      for (int i = 0; i < 4; i++) drive(i[0]);
      zeros("in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) drive(i[0]);
      zeros("idle_toggle");

      // Nominal count[0] pattern, lock, single long period, relock
      start = 1'b1;
      drive(0); drive(0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 1);
      period(3, 1, 1, 1, 1);
      period(4, 1, 1, 0, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 1);
      period(3, 1, 0, 0, 0);
      start = 1'b0;
      drive(0);
      zeros("nominal_stop");

      // Phase-shifted input already high when start rises: no false rise
      start = 1'b1;
      drive(1); drive(1); drive(1);
      drive(0); drive(0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 1);
      period(3, 1, 1, 1, 1);
      period(3, 1, 0, 0, 0);
      start = 1'b0;
      drive(0);
      zeros("phase_stop");

      // Timeout after lock: err exactly when cnt reaches 255
      start = 1'b1;
      drive(0); drive(0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 1);
      drive(1);
      for (int i = 0; i < 254; i++) drive(0);
      chk("err_before_timeout", int'(err), 0);
      chk("locked_before_timeout", int'(locked), 1);
      drive(0);
      chk("err_at_timeout", int'(err), 1);
      chk("locked_at_timeout", int'(locked), 0);
      chk("match_at_timeout", int'(match), 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 0, 0, 0);
      chk("err_sticky", int'(err), 1);
      start = 1'b0;
      drive(0);
      zeros("timeout_stop");

      // Abort on the same edge as a rise, then restart from SEEK
      start = 1'b1;
      drive(0); drive(0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 0, 0, 0);
      start = 1'b0;
      drive(1);
      zeros("abort_on_rise");
      drive(0);
      start = 1'b1;
      drive(0); drive(0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 1, 1, 0);
      period(3, 1, 0, 0, 0);
      start = 1'b0;
      drive(0);
      zeros("restart_stop");

      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/div_ratio_monitor.md
# div_ratio_monitor

Receive-side checker for the clock-divider outputs. It samples a divided signal such as `count[0]` or `count[1]` of the divide-by-3 counter in the same `clk` domain and measures each period and high time in `clk` cycles. It compares every measurement with the expected ratio and duty, and asserts `locked` after a run of consecutive good periods. It sits beside the divider in the clock-generation block as a self-check and bring-up monitor.

## Interface
Parameters:
- `CNT_W`, 8: width of the period and high-time counters and outputs.
- `EXP_PERIOD`, 3: expected period in `clk` cycles.
- `EXP_HIGH`, 1: expected high time in `clk` cycles.
- `LOCK_CNT`, 4: number of consecutive matching periods required to assert `locked`.

Ports:
- `clk`  in  1  single clock; every flop is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  monitor enable; low forces IDLE and clears the measurement state.
- `sig_in`  in  1  divided signal, synchronous to `clk`.
- `period_o`  out  `CNT_W`  last measured period.
- `high_o`  out  `CNT_W`  last measured high time.
- `meas_valid`  out  1  one-cycle pulse when `period_o`/`high_o` update.
- `match`  out  1  last measurement equals (`EXP_PERIOD`, `EXP_HIGH`).
- `locked`  out  1  `LOCK_CNT` consecutive matches seen.
- `err`  out  1  sticky period timeout.

## Operation
- Input register `sig_q` holds the previous `sig_in`. A rising edge (`rise`) is `sig_in & ~sig_q`.
- States:
  - IDLE: entered from reset or whenever `start`=0.
  - SEEK: waiting for the first `rise`.
  - MEAS: measuring between rises.
- Transitions:
  - IDLE→SEEK when `start`=1.
  - SEEK→MEAS on `rise`, with `cnt`←1 and `hcnt`←1.
  - MEAS→MEAS on `rise`: close the measurement, then reload `cnt`←1 and `hcnt`←1.
  - MEAS→SEEK on timeout.
  - Any state→IDLE when `start`=0.
- Counting in MEAS with no `rise`:
  - `cnt` increments every cycle.
  - `hcnt` increments when `sig_in`=1.
- Closing a measurement: `period_o`←`cnt`, `high_o`←`hcnt`, `meas_valid`←1, and `match`←(`cnt`==`EXP_PERIOD` && `hcnt`==`EXP_HIGH`).
- Lock counter `mcnt` (width $clog2(`LOCK_CNT`+1)), updated on each close:
  - match: increments, saturating at `LOCK_CNT`.
  - mismatch: clears to 0.
  - `locked` = (`mcnt`==`LOCK_CNT`).
- Timeout: `cnt`==2^`CNT_W`−1 with no `rise` sets `err` and clears `mcnt`, `locked` and `match`; state goes to SEEK. `err` remains set until `start`=0 or reset.
- `start`=0 has priority over a simultaneous `rise` or timeout. All state and outputs clear, including `period_o` and `high_o`.
- Arithmetic: counters are unsigned `CNT_W` bits and never wrap, because the timeout fires first.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE; `sig_q`, `cnt`, `hcnt`, `mcnt`=0; every output=0.
- `sig_q` updates in IDLE as well, so a `sig_in` already high when `start` rises produces no false `rise`.
- All outputs are registered. A measurement closed at the clock edge that samples `rise` is visible in the following cycle, and `meas_valid` is high for exactly that one cycle.
- First `meas_valid`: the second `rise` after SEEK is entered.
- `locked` rises in the same cycle as the `LOCK_CNT`-th matching `meas_valid`. It falls in the cycle after a mismatching close or a timeout, i.e. with that `meas_valid` or with `err`.
- Back-to-back rises (period 1 is impossible with this edge detector; the minimum is 2) must still produce one `meas_valid` per rise.

## Structure
- A shared clock-gen package holds the state enum (`IDLE`, `SEEK`, `MEAS`) and the default constants `EXP_PERIOD`=3 and `EXP_HIGH`=1. The divider uses these constants too.
- One sub-module, `edge_period_counter`, contains `sig_q`, `rise`, `cnt`, `hcnt` and the timeout compare.
- The top level contains the FSM, the output registers and the lock counter.

## Test plan
- Reset/idle: `rst_n`=0 then 1 with `start`=0 and `sig_in` toggling → all outputs stay 0.
- Nominal: drive `sig_in`=`count[0]` of a divide-by-3 counter (pattern 0,1,0 repeating), `start`=1 →
  - `meas_valid` every 3 cycles after the first close;
  - `period_o`=3, `high_o`=1, `match`=1;
  - `locked`=1 on the 4th `meas_valid`.
- Phase shift: `sig_in`=`count[1]` (pattern 0,0,1) → same values; lock timing shifted by the edge phase only.
- Mismatch: after lock, insert one period of 4 (high 1) → `period_o`=4, `match`=0, `locked`=0 in the same cycle as that `meas_valid`; relocks after 4 further good periods.
- Timeout: hold `sig_in`=0 for 255 cycles in MEAS with `CNT_W`=8 → `err`=1 and `locked`=0; `err` persists until `start`=0.
- Mid-operation abort: drop `start` in the same cycle as a `rise` → no `meas_valid`, all outputs 0 next cycle; re-raising `start` restarts from SEEK.
